msk_rnd_gen: RTL and testbench

- Fresh-randomness source for masked gadgets of order d, e.g. the PINI masked AND, which consumes d*(d-1)/2 random bits per cycle.
- 127-bit LFSR (recurrence b[n+127] = b[n] ^ b[n+126]) advanced N_RND steps per cycle, unrolled.
- Seeded through a word-serial valid/ready port, then run through a warm-up phase.
- Sits directly upstream of the gadget random input; one instance per gadget group.

---
 rtl/msk_rnd_gen.sv | 202 ++++++++++++++++++++
 tb/tb_msk_rnd_gen.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/msk_rnd_gen.sv
// msk_rnd_gen: fresh-randomness source for a group of masked gadgets of order D.
//
// A 127-bit LFSR (fb = s[126] ^ s[0], shift left, fb enters at s[0]) is
// stepped N_RND = D*(D-1)/2 times per cycle, unrolled. Bit k of each new
// output word is the feedback bit of step k. The LFSR is loaded through a
// word-serial valid/ready seed port. After the fourth word it runs WARMUP
// discarded advances and then serves bits on request.
//
// State  | meaning
// -------+-------------------------------------------------------------
// IDLE   | after reset; waits for start_reseed_i
// SEED   | accepts four seed words (word i -> s[32i+31:32i])
// WARM   | advances every cycle, output suppressed, WARMUP cycles
// RUN    | advances on en_i and presents fresh bits one cycle later
//
// Ports:
//   clk_i           clock, rising edge
//   rst_i           synchronous active-high reset, priority over all inputs
//   start_reseed_i  pulse, request a new seed load
//   seed_in_i       seed word
//   seed_valid_i    seed_in_i valid
//   seed_ready_o    seed word accepted this cycle (state SEED)
//   en_i            advance request
//   rnd_out_o       registered random bits
//   rnd_valid_o     rnd_out_o is fresh this cycle
//   busy_o          high whenever the FSM is not in RUN

module msk_rnd_gen #(
   parameter int D      = 2,   // masking order, 2..16
   parameter int WARMUP = 16,  // discarded advance cycles, 0..255
   localparam int N_RND  = D * (D - 1) / 2,
   localparam int SEED_W = 32
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              start_reseed_i,
   input  logic [SEED_W-1:0] seed_in_i,
   input  logic              seed_valid_i,
   output logic              seed_ready_o,
   input  logic              en_i,
   output logic [N_RND-1:0]  rnd_out_o,
   output logic              rnd_valid_o,
   output logic              busy_o
);

   localparam logic [7:0] WARM_INIT = 8'(WARMUP);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_SEED = 2'd1,
      ST_WARM = 2'd2,
      ST_RUN  = 2'd3
   } state_e;

   state_e             state_q, state_d;
   logic [126:0]       lfsr_q, lfsr_d;
   logic [1:0]         seed_cnt_q, seed_cnt_d;
   logic [7:0]         warm_cnt_q, warm_cnt_d;
   logic [N_RND-1:0]   rnd_q, rnd_d;
   logic               valid_q, valid_d;

   logic [126:0]       adv_s;
   logic [N_RND-1:0]   adv_bits;
   logic               adv_fb;
   logic [126:0]       loaded;
   logic               seed_hs;

   // ---------------------------------------------------------------
   // FSM: state register
   // ---------------------------------------------------------------
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // ---------------------------------------------------------------
   // FSM: next state
   // ---------------------------------------------------------------
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: begin
            if (start_reseed_i) state_d = ST_SEED;
         end
         ST_SEED: begin
            // A reseed request restarts the load and discards a coincident word.
            if (!start_reseed_i && seed_hs && seed_cnt_q == 2'd3) begin
               state_d = (WARMUP == 0) ? ST_RUN : ST_WARM;
            end
         end
         ST_WARM: begin
            if (start_reseed_i)              state_d = ST_SEED;
            else if (warm_cnt_q == 8'd1)     state_d = ST_RUN;
         end
         ST_RUN: begin
            if (start_reseed_i) state_d = ST_SEED;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // ---------------------------------------------------------------
   // FSM: outputs
   // ---------------------------------------------------------------
   always_comb begin
      seed_ready_o = (state_q == ST_SEED);
      busy_o       = (state_q != ST_RUN);
   end

   assign seed_hs = seed_valid_i && seed_ready_o;

   // ---------------------------------------------------------------
   // One advance: N_RND chained single steps
   // ---------------------------------------------------------------
   always_comb begin
      adv_s    = lfsr_q;
      adv_bits = '0;
      adv_fb   = 1'b0;
      for (int k = 0; k < N_RND; k++) begin
         adv_fb      = adv_s[126] ^ adv_s[0];
         adv_bits[k] = adv_fb;
         adv_s       = {adv_s[125:0], adv_fb};
      end
   end

   // ---------------------------------------------------------------
   // Datapath next state
   // ---------------------------------------------------------------
   always_comb begin
      lfsr_d     = lfsr_q;
      seed_cnt_d = seed_cnt_q;
      warm_cnt_d = warm_cnt_q;
      rnd_d      = rnd_q;
      valid_d    = 1'b0;
      loaded     = lfsr_q;
      case (state_q)
         ST_IDLE: begin
            if (start_reseed_i) seed_cnt_d = 2'd0;
         end
         ST_SEED: begin
            if (start_reseed_i) begin
               seed_cnt_d = 2'd0;
            end else if (seed_hs) begin
               case (seed_cnt_q)
                  2'd0: loaded[31:0]   = seed_in_i;
                  2'd1: loaded[63:32]  = seed_in_i;
                  2'd2: loaded[95:64]  = seed_in_i;
                  default: loaded[126:96] = seed_in_i[30:0];
               endcase
               // An all-zero state would lock the LFSR at zero forever.
               if (seed_cnt_q == 2'd3 && loaded == '0) loaded[0] = 1'b1;
               lfsr_d     = loaded;
               seed_cnt_d = seed_cnt_q + 2'd1;
               if (seed_cnt_q == 2'd3) warm_cnt_d = WARM_INIT;
            end
         end
         ST_WARM: begin
            if (start_reseed_i) begin
               seed_cnt_d = 2'd0;
               rnd_d      = '0;
            end else begin
               lfsr_d     = adv_s;
               warm_cnt_d = warm_cnt_q - 8'd1;
            end
         end
         ST_RUN: begin
            if (start_reseed_i) begin
               seed_cnt_d = 2'd0;
               rnd_d      = '0;
            end else if (en_i) begin
               lfsr_d  = adv_s;
               rnd_d   = adv_bits;
               valid_d = 1'b1;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         lfsr_q     <= '0;
         seed_cnt_q <= 2'd0;
         warm_cnt_q <= 8'd0;
         rnd_q      <= '0;
         valid_q    <= 1'b0;
      end else begin
         lfsr_q     <= lfsr_d;
         seed_cnt_q <= seed_cnt_d;
         warm_cnt_q <= warm_cnt_d;
         rnd_q      <= rnd_d;
         valid_q    <= valid_d;
      end
   end

   assign rnd_out_o   = rnd_q;
   assign rnd_valid_o = valid_q;

endmodule

// File: tb/tb_msk_rnd_gen.sv
// Bench for msk_rnd_gen. Two instances share one stimulus stream:
//   a: D=3 (3 bits/cycle), WARMUP=0
//   b: D=2 (1 bit/cycle),  WARMUP=16
// The reference model treats the generator as a bit stream obeying
// b[n+127] = b[n] ^ b[n+126], whose first 127 bits come from the seed
// (b[j] = seed bit 126-j); outputs consume that stream in order.

module tb_msk_rnd_gen;

   localparam int M_IDLE = 0, M_SEED = 1, M_WARM = 2, M_RUN = 3;

   logic        clk = 1'b0;
   logic        rst = 1'b0, start_reseed = 1'b0, seed_valid = 1'b0, en = 1'b0;
   logic [31:0] seed_in = '0;

   logic        seed_ready_a, rnd_valid_a, busy_a;
   logic [2:0]  rnd_out_a;
   logic        seed_ready_b, rnd_valid_b, busy_b;
   logic [0:0]  rnd_out_b;

   int n_tests = 0;
   int n_fail  = 0;

   int          mode[2]      = '{M_IDLE, M_IDLE};
   int          wcnt[2]      = '{0, 0};
   int          warm_left[2] = '{0, 0};
   logic [31:0] words[2][4];
   bit          bits_a[$];
   bit          bits_b[$];
   logic [127:0] exp_a[$];
   logic [127:0] exp_b[$];

   always #5 clk = ~clk;

   msk_rnd_gen #(.D(3), .WARMUP(0)) u_a (
      .clk_i(clk), .rst_i(rst), .start_reseed_i(start_reseed),
      .seed_in_i(seed_in), .seed_valid_i(seed_valid), .seed_ready_o(seed_ready_a),
      .en_i(en), .rnd_out_o(rnd_out_a), .rnd_valid_o(rnd_valid_a), .busy_o(busy_a));

   msk_rnd_gen #(.D(2), .WARMUP(16)) u_b (
      .clk_i(clk), .rst_i(rst), .start_reseed_i(start_reseed),
      .seed_in_i(seed_in), .seed_valid_i(seed_valid), .seed_ready_o(seed_ready_b),
      .en_i(en), .rnd_out_o(rnd_out_b), .rnd_valid_o(rnd_valid_b), .busy_o(busy_b));

   function automatic int nrnd(input int i);
      return (i == 0) ? 3 : 1;
   endfunction

   function automatic int warmup(input int i);
      return (i == 0) ? 0 : 16;
   endfunction

   function automatic bit gen_bit(input int i);
      bit b;
      if (i == 0) begin
         b = bits_a[bits_a.size() - 127] ^ bits_a[bits_a.size() - 1];
         bits_a.push_back(b);
      end else begin
         b = bits_b[bits_b.size() - 127] ^ bits_b[bits_b.size() - 1];
         bits_b.push_back(b);
      end
      return b;
   endfunction

   function automatic logic [127:0] take_word(input int i);
      logic [127:0] v;
      v = '0;
      for (int k = 0; k < nrnd(i); k++) v[k] = gen_bit(i);
      return v;
   endfunction

   task automatic load_seed(input int i);
      logic [126:0] s;
      logic [127:0] junk;
      s = {words[i][3][30:0], words[i][2], words[i][1], words[i][0]};
      if (s == '0) s = 127'd1;
      if (i == 0) bits_a.delete(); else bits_b.delete();
      for (int j = 0; j < 127; j++) begin
         if (i == 0) bits_a.push_back(s[126 - j]); else bits_b.push_back(s[126 - j]);
      end
      for (int w = 0; w < warmup(i); w++) junk = take_word(i);
      mode[i] = (warmup(i) == 0) ? M_RUN : M_WARM;
      warm_left[i] = warmup(i);
   endtask

   task automatic model_step(input int i, input logic r, input logic st, input logic sv,
                             input logic [31:0] sd, input logic e);
      if (r) begin
         mode[i] = M_IDLE;
      end else begin
         case (mode[i])
            M_IDLE: if (st) begin mode[i] = M_SEED; wcnt[i] = 0; end
            M_SEED: begin
               if (st) wcnt[i] = 0;
               else if (sv) begin
                  words[i][wcnt[i]] = sd;
                  wcnt[i]++;
                  if (wcnt[i] == 4) load_seed(i);
               end
            end
            M_WARM: begin
               if (st) begin mode[i] = M_SEED; wcnt[i] = 0; end
               else begin
                  warm_left[i]--;
                  if (warm_left[i] == 0) mode[i] = M_RUN;
               end
            end
            default: begin
               if (st) begin mode[i] = M_SEED; wcnt[i] = 0; end
               else if (e) begin
                  if (i == 0) exp_a.push_back(take_word(0));
                  else        exp_b.push_back(take_word(1));
               end
            end
         endcase
      end
   endtask

   task automatic tick(input logic r, input logic st, input logic sv,
                       input logic [31:0] sd, input logic e);
      rst = r; start_reseed = st; seed_valid = sv; seed_in = sd; en = e;
      model_step(0, r, st, sv, sd, e);
      model_step(1, r, st, sv, sd, e);
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Scoreboard monitors: every valid output must match the next expected word.
   always @(negedge clk) begin
      if (rnd_valid_a === 1'b1) begin
         n_tests++;
         if (exp_a.size() == 0) begin
            n_fail++;
            $display("FAIL mon_a: unexpected valid word %0h, none expected", rnd_out_a);
         end else begin
            logic [127:0] e;
            e = exp_a.pop_front();
            if ({125'b0, rnd_out_a} !== e) begin
               n_fail++;
               $display("FAIL mon_a: got %0h, expected %0h (t=%0t)", rnd_out_a, e, $time);
            end
         end
      end
   end

   always @(negedge clk) begin
      if (rnd_valid_b === 1'b1) begin
         n_tests++;
         if (exp_b.size() == 0) begin
            n_fail++;
            $display("FAIL mon_b: unexpected valid word %0h, none expected", rnd_out_b);
         end else begin
            logic [127:0] e;
            e = exp_b.pop_front();
            if ({127'b0, rnd_out_b} !== e) begin
               n_fail++;
               $display("FAIL mon_b: got %0h, expected %0h (t=%0t)", rnd_out_b, e, $time);
            end
         end
      end
   end

   // Called right after the edge that accepted seed word 3 of a seed whose
   // effective state is 1: a produces 126 ones then a different word, b warms up.
   task automatic run_after_seed();
      chk("b_warm_busy0", busy_b, 1);
      chk("b_warm_valid0", rnd_valid_b, 0);
      for (int c = 1; c <= 43; c++) begin
         tick(0, 0, 0, '0, 1);
         chk("a_run_valid", rnd_valid_a, 1);
         if (c <= 42) chk("a_ones", rnd_out_a, 3'b111);
         else         chk("a_after_ones_differs", rnd_out_a != 3'b111, 1);
         if (c <= 15) begin
            chk("b_warm_busy", busy_b, 1);
            chk("b_warm_valid", rnd_valid_b, 0);
         end else if (c == 16) begin
            chk("b_warm_end_busy", busy_b, 0);
            chk("b_warm_end_valid", rnd_valid_b, 0);
         end else if (c == 17) begin
            chk("b_first_valid", rnd_valid_b, 1);
         end
      end
   endtask

   initial begin
      logic [2:0] held;
      int sent;
      logic sv;

      tick(1, 0, 0, '0, 0);
      tick(1, 0, 0, '0, 1);
      chk("rst_out_a", rnd_out_a, 0);
      chk("rst_valid_a", rnd_valid_a, 0);
      chk("rst_busy_a", busy_a, 1);
      chk("rst_ready_a", seed_ready_a, 0);
      chk("rst_busy_b", busy_b, 1);

      for (int c = 0; c < 10; c++) begin
         tick(0, 0, 0, '0, 1);
         chk("idle_out_a", rnd_out_a, 0);
         chk("idle_valid_a", rnd_valid_a, 0);
         chk("idle_busy_a", busy_a, 1);
         chk("idle_ready_a", seed_ready_a, 0);
      end

      // seed 1,0,0,0
      tick(0, 1, 0, '0, 0);
      chk("seed_ready_a", seed_ready_a, 1);
      chk("seed_ready_b", seed_ready_b, 1);
      tick(0, 0, 1, 32'd1, 0);
      tick(0, 0, 1, 32'd0, 0);
      tick(0, 0, 1, 32'd0, 0);
      chk("seed_busy_a", busy_a, 1);
      tick(0, 0, 1, 32'd0, 0);
      chk("seeded_ready_a", seed_ready_a, 0);
      chk("seeded_busy_a", busy_a, 0);
      run_after_seed();

      // stall: en 1,0,0,1
      tick(0, 0, 0, '0, 1);
      chk("stall_v1", rnd_valid_a, 1);
      held = rnd_out_a;
      tick(0, 0, 0, '0, 0);
      chk("stall_v2", rnd_valid_a, 0);
      chk("stall_hold2", rnd_out_a, held);
      tick(0, 0, 0, '0, 0);
      chk("stall_v3", rnd_valid_a, 0);
      chk("stall_hold3", rnd_out_a, held);
      tick(0, 0, 0, '0, 1);
      chk("stall_v4", rnd_valid_a, 1);

      for (int c = 0; c < 150; c++) tick(0, 0, 0, '0, 1'($urandom_range(0, 1)));

      // mid-run reseed, then a discarded word, then an all-zero seed
      tick(0, 1, 0, '0, 1);
      chk("reseed_out_a", rnd_out_a, 0);
      chk("reseed_valid_a", rnd_valid_a, 0);
      chk("reseed_ready_a", seed_ready_a, 1);
      chk("reseed_out_b", rnd_out_b, 0);
      chk("reseed_ready_b", seed_ready_b, 1);
      tick(0, 1, 1, 32'hdeadbeef, 1);
      tick(0, 0, 1, 32'd0, 0);
      tick(0, 0, 1, 32'd0, 0);
      tick(0, 0, 1, 32'd0, 0);
      chk("discard_still_seeding", seed_ready_a, 1);
      tick(0, 0, 1, 32'd0, 0);
      chk("zero_seed_busy_a", busy_a, 0);
      run_after_seed();

      // random seed with gaps, then random en
      tick(0, 1, 0, '0, 0);
      sent = 0;
      for (int c = 0; c < 64 && sent < 4; c++) begin
         sv = 1'($urandom_range(0, 1));
         tick(0, 0, sv, $urandom, 1'($urandom_range(0, 1)));
         if (sv) sent++;
      end
      for (int c = 0; c < 200; c++) tick(0, 0, 0, '0, 1'($urandom_range(0, 1)));

      for (int c = 0; c < 3; c++) tick(0, 0, 0, '0, 0);
      chk("drain_a", exp_a.size(), 0);
      chk("drain_b", exp_b.size(), 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
